// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the configurable UART receiver and the
// planned parametrised transmitter.
//   - uart_state_e : receiver frame state machine encoding
//   - PARITY_*     : parity mode selectors for the PARITY parameter
//   - baud_div()   : clocks per bit for a given clock and line rate
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_COMMIT    = 3'd5,
        ST_WAIT_HIGH = 3'd6
    } uart_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Truncating division: clocks per bit
    function automatic int baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if: one-entry valid/ready delivery channel of the receiver.
//   data_out   : received word, LSB first on the line
//   data_valid : data_out holds an unread word
//   data_ready : consumer accepts when data_valid && data_ready
//   parity_err : parity mismatch, qualified with data_valid
//   frame_err  : a stop bit was sampled low, qualified with data_valid
// master = receiver side, slave = consumer side.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ready;
    logic                 parity_err;
    logic                 frame_err;

    modport master (
        output data_out, data_valid, parity_err, frame_err,
        input  data_ready
    );

    modport slave (
        input  data_out, data_valid, parity_err, frame_err,
        output data_ready
    );
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter shared by the UART receiver and transmitter.
//   clk, rst  : system clock, synchronous active-high reset
//   clr       : restart the bit period (count returns to 0 next cycle)
//   half_tick : count == BAUD_CLK/2 - 1 (middle of the first bit)
//   full_tick : count == BAUD_CLK - 1 (middle of every later bit); wraps to 0
module uart_baud_tick #(
    parameter int BAUD_CLK = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic half_tick,
    output logic full_tick
);
    localparam int CNT_W = (BAUD_CLK > 1) ? $clog2(BAUD_CLK) : 1;
    localparam logic [CNT_W-1:0] HALF_V = CNT_W'(BAUD_CLK / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_V = CNT_W'(BAUD_CLK - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign half_tick = (cnt_q == HALF_V);
    assign full_tick = (cnt_q == FULL_V);

    // Next count: restart on clear or at the end of a bit period
    always_comb begin
        cnt_d = cnt_q;
        if (clr || full_tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver (5..9 data bits, none/odd/even
// parity, 1 or 2 stop bits) with false-start rejection and a one-entry
// valid/ready output register.
//   clk, rst  : system clock, synchronous active-high reset
//   uart_rx   : asynchronous serial line, idles high
//   rx_if     : word delivery channel (data_out/valid/ready/parity_err/frame_err)
//   break_det : one-cycle pulse, all data, parity and first stop bit low
//   overrun   : one-cycle pulse, a frame was dropped because the word was unread
//   busy      : receiver not in IDLE
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLK       = 50000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             uart_rx,
    uart_rx_cfg_if.master    rx_if,
    output logic             break_det,
    output logic             overrun,
    output logic             busy
);
    localparam int BAUD_CLK = baud_div(CLK, BAUD);
    localparam int BC_W     = $clog2(DATA_BITS + 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_cfg: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end
    if (BAUD_CLK < 4) begin : g_bad_baud_clk
        $error("uart_rx_cfg: CLK/BAUD must be at least 4");
    end

    uart_state_e          state_q, state_d;
    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_acc_q, perr_acc_d;
    logic                 ferr_acc_q, ferr_acc_d;
    logic                 zero_q, zero_d;       // every bit so far was low
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 data_valid_q, data_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 break_q, break_d;
    logic                 overrun_q, overrun_d;
    logic                 busy_q;
    logic                 half_tick_s, full_tick_s, clr_s;
    logic                 par_exp_s;

    // Counter restarts whenever the state machine changes state
    assign clr_s = (state_d != state_q);

    uart_baud_tick #(.BAUD_CLK(BAUD_CLK)) u_baud_tick (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr_s),
        .half_tick (half_tick_s),
        .full_tick (full_tick_s)
    );

    assign par_exp_s = (PARITY == PARITY_EVEN) ? (^shift_q) : ~(^shift_q);

    assign rx_if.data_out   = data_out_q;
    assign rx_if.data_valid = data_valid_q;
    assign rx_if.parity_err = parity_err_q;
    assign rx_if.frame_err  = frame_err_q;
    assign break_det        = break_q;
    assign overrun          = overrun_q;
    assign busy             = busy_q;

    // Next-state, datapath and output-register logic
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        perr_acc_d   = perr_acc_q;
        ferr_acc_d   = ferr_acc_q;
        zero_d       = zero_q;
        data_out_d   = data_out_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        break_d      = 1'b0;
        overrun_d    = 1'b0;
        if (data_valid_q && rx_if.data_ready) begin
            data_valid_d = 1'b0;
        end else begin
            data_valid_d = data_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (half_tick_s) begin
                    if (rx_sync_q) begin
                        state_d = ST_IDLE;   // line back high: false start
                    end else begin
                        state_d    = ST_DATA;
                        bit_cnt_d  = '0;
                        perr_acc_d = 1'b0;
                        ferr_acc_d = 1'b0;
                        zero_d     = 1'b1;
                    end
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (full_tick_s) begin
                    shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
                    if (rx_sync_q) begin
                        zero_d = 1'b0;
                    end else begin
                        zero_d = zero_q;
                    end
                    if (bit_cnt_q == BC_W'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (full_tick_s) begin
                    perr_acc_d = rx_sync_q ^ par_exp_s;
                    if (rx_sync_q) begin
                        zero_d = 1'b0;
                    end else begin
                        zero_d = zero_q;
                    end
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (full_tick_s) begin
                    if (!rx_sync_q) begin
                        ferr_acc_d = 1'b1;
                    end else begin
                        ferr_acc_d = ferr_acc_q;
                    end
                    // Break only looks at the first stop bit
                    if ((bit_cnt_q == BC_W'(0)) && rx_sync_q) begin
                        zero_d = 1'b0;
                    end else begin
                        zero_d = zero_q;
                    end
                    if (bit_cnt_q == BC_W'(STOP_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = ST_COMMIT;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_COMMIT: begin
                break_d = zero_q;
                // A simultaneous accept frees the register, so it is a load
                if (!data_valid_q || rx_if.data_ready) begin
                    data_out_d   = shift_q;
                    data_valid_d = 1'b1;
                    parity_err_d = (PARITY != PARITY_NONE) ? perr_acc_q : 1'b0;
                    frame_err_d  = ferr_acc_q;
                end else begin
                    overrun_d = 1'b1;
                end
                state_d = rx_sync_q ? ST_IDLE : ST_WAIT_HIGH;
            end
            ST_WAIT_HIGH: begin
                if (rx_sync_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_HIGH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, synchroniser, datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            perr_acc_q   <= 1'b0;
            ferr_acc_q   <= 1'b0;
            zero_q       <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            break_q      <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_meta_q    <= uart_rx;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            perr_acc_q   <= perr_acc_d;
            ferr_acc_q   <= ferr_acc_d;
            zero_q       <= zero_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            break_q      <= break_d;
            overrun_q    <= overrun_d;
            busy_q       <= (state_d != ST_IDLE);
        end
    end
endmodule
